// File: rtl/alu_muldiv.sv
// alu_muldiv -- EX-stage datapath ALU for the MIPS32 core.
//
// Single-cycle ops (nop, add, sub, and, or, slt, sll, lui) are purely
// combinational on busC. Multiply and divide run iteratively, one result
// bit per clock, over WIDTH cycles and write the HI/LO registers at the end.
// A start/busy/done handshake launches them, and stall freezes the pipeline
// while an instruction that touches HI/LO waits for a pending result.
//
// Ports:
//   clk     rising-edge clock for all state
//   rst     synchronous, active-high reset (aborts any mul/div in flight)
//   busA    operand A (rs): dividend / multiplicand / mthi-mtlo source
//   busB    operand B (rt): divisor / multiplier
//   ALUOp   operation select (0..F)
//   start   instruction-valid qualifier for ops 8..B, E, F
//   busC    combinational result
//   zero    busC == 0
//   OFsign  signed overflow of add/sub
//   busy    mul/div iteration in progress
//   done    one-cycle pulse after HI/LO were written by mul/div
//   stall   busy while ALUOp is one of the HI/LO ops (8..F)

module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [3:0]       ALUOp,
    input  logic             start,
    output logic [WIDTH-1:0] busC,
    output logic             zero,
    output logic             OFsign,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] acc_hi, acc_lo, mag_b;
    logic [CW-1:0]    count;
    logic             neg_main, neg_rem;

    logic             launch, move_hi, move_lo;
    logic             op_signed, sign_a, sign_b, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    logic [WIDTH:0]   add_ext, sub_ext;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [2*WIDTH-1:0] prod, prod_fix;

    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi_n, div_lo_n, quo_fix, rem_fix;

    // Launch and move qualifiers. Ops 8..B share the 10xx prefix; the
    // low bit selects unsigned, bit 1 selects divide.
    always_comb begin
        launch    = start & ~busy & (ALUOp[3:2] == 2'b10);
        move_hi   = start & ~busy & (ALUOp == 4'hE);
        move_lo   = start & ~busy & (ALUOp == 4'hF);
        op_signed = ~ALUOp[0];
        sign_a    = op_signed & busA[WIDTH-1];
        sign_b    = op_signed & busB[WIDTH-1];
        abs_a     = sign_a ? -busA : busA;
        abs_b     = sign_b ? -busB : busB;
        b_zero    = (busB == '0);
    end

    // State register for the mul/div sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. A new launch is accepted from the
    // done cycle as well as from idle, so back-to-back ops lose no cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (launch) begin
                    state_next = ALUOp[1] ? ST_DIV : ST_MUL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        stall = busy & ALUOp[3];
    end

    // One iteration of each algorithm. Multiply: {acc_hi,acc_lo} shifts
    // right while the multiplicand magnitude is added when the multiplier
    // LSB is set. Divide: restoring step, quotient bits enter acc_lo from
    // the right as dividend bits leave into the remainder in acc_hi. The
    // subtraction is only kept when it cannot borrow, so the truncated
    // WIDTH-bit difference is exact.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        prod      = {mul_hi_n, mul_lo_n};
        prod_fix  = neg_main ? -prod : prod;

        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift[WIDTH-1:0] - mag_b;
        div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};
        quo_fix   = neg_main ? -div_lo_n : div_lo_n;
        rem_fix   = neg_rem ? -div_hi_n : div_hi_n;
    end

    // Datapath registers. Divide by zero falls out of the restoring loop
    // naturally (all-ones quotient, remainder equals the dividend
    // magnitude); only the quotient sign fix is suppressed so LO stays all
    // ones and HI regains the dividend's sign. Signed MIN / -1 also needs
    // no special case: the magnitude quotient negates back to MIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_b    <= '0;
            count    <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        count  <= '0;
                        acc_hi <= '0;
                        if (ALUOp[1]) begin
                            acc_lo   <= abs_a;
                            mag_b    <= abs_b;
                            neg_main <= (sign_a ^ sign_b) & ~b_zero;
                            neg_rem  <= sign_a;
                        end else begin
                            acc_lo   <= abs_b;
                            mag_b    <= abs_a;
                            neg_main <= sign_a ^ sign_b;
                            neg_rem  <= 1'b0;
                        end
                    end else if (move_hi) begin
                        hi <= busA;
                    end else if (move_lo) begin
                        lo <= busA;
                    end
                end
                ST_MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= prod_fix[2*WIDTH-1:WIDTH];
                        lo    <= prod_fix[WIDTH-1:0];
                        count <= '0;
                    end
                end
                ST_DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= rem_fix;
                        lo    <= quo_fix;
                        count <= '0;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    // Result mux. Add/sub are done one bit wider with sign extension so the
    // top two bits give overflow and the true sign for slt.
    always_comb begin
        add_ext = {busA[WIDTH-1], busA} + {busB[WIDTH-1], busB};
        sub_ext = {busA[WIDTH-1], busA} - {busB[WIDTH-1], busB};
        busC    = '0;
        OFsign  = 1'b0;
        case (ALUOp)
            4'h1: begin
                busC   = add_ext[WIDTH-1:0];
                OFsign = add_ext[WIDTH] ^ add_ext[WIDTH-1];
            end
            4'h2: begin
                busC   = sub_ext[WIDTH-1:0];
                OFsign = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];
            end
            4'h3: busC = busA & busB;
            4'h4: busC = busA | busB;
            4'h5: busC = {{(WIDTH-1){1'b0}}, sub_ext[WIDTH]};
            4'h6: busC = busA << busB[SHW-1:0];
            4'h7: busC = busB << (WIDTH / 2);
            4'hC: busC = hi;
            4'hD: busC = lo;
            default: busC = '0;
        endcase
        zero = (busC == '0);
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Testbench for alu_muldiv (WIDTH = 32): directed cases for the documented
// corner values plus randomized single-cycle and mul/div operations checked
// against an arithmetic reference model.

module tb_alu_muldiv;

    logic        clk;
    logic        rst;
    logic [31:0] busA, busB;
    logic [3:0]  ALUOp;
    logic        start;
    logic [31:0] busC;
    logic        zero, OFsign, busy, done, stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] modelHi, modelLo;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .busA   (busA),
        .busB   (busB),
        .ALUOp  (ALUOp),
        .start  (start),
        .busC   (busC),
        .zero   (zero),
        .OFsign (OFsign),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction's inputs and let the combinational result settle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic st);
        ALUOp = op;
        busA  = a;
        busB  = b;
        start = st;
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference for the single-cycle ops, straight from the arithmetic.
    function automatic void refAlu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] res,
                                   output logic of);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        of = 1'b0;
        res = '0;
        case (op)
            4'h1: begin r = sa + sb; res = r[31:0]; of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h2: begin r = sa - sb; res = r[31:0]; of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            4'h3: res = a & b;
            4'h4: res = a | b;
            4'h5: res = (sa < sb) ? 32'd1 : 32'd0;
            4'h6: res = a << (b % 32);
            4'h7: res = b * 32'd65536;
            default: res = '0;
        endcase
    endfunction

    // Reference for mul/div results, using 64-bit integer arithmetic.
    function automatic void refMulDiv(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'h8: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            4'h9: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            4'hA: begin
                if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 0) begin lo = 32'hFFFFFFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Launch one mul/div, time its busy window and done pulse, then read
    // HI/LO back through mfhi/mflo.
    task automatic runMulDiv(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expHi,
                             input logic [31:0] expLo, input string tag);
        int cyc;
        applyStimulus(op, a, b, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        checkOutput({tag, " busy cycles"}, cyc, 32);
        checkOutput({tag, " done pulse"}, {31'd0, done}, 32'd1);
        tick();
        checkOutput({tag, " done cleared"}, {31'd0, done}, 32'd0);
        modelHi = expHi;
        modelLo = expLo;
        applyStimulus(4'hC, 32'h0, 32'h0, 1'b0);
        checkOutput({tag, " HI"}, busC, modelHi);
        applyStimulus(4'hD, 32'h0, 32'h0, 1'b0);
        checkOutput({tag, " LO"}, busC, modelLo);
    endtask

    initial begin
        int cyc, stallBad, doneSeen;
        logic [31:0] expRes, eh, el;
        logic expOf;
        logic [3:0] op;
        logic [31:0] a, b;

        rst = 1'b1;
        applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        modelHi = '0;
        modelLo = '0;

        // Reset state
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("nop busC", busC, 32'd0);
        checkOutput("nop zero", {31'd0, zero}, 32'd1);
        applyStimulus(4'hC, 32'h0, 32'h0, 1'b0);
        checkOutput("reset HI", busC, 32'd0);
        applyStimulus(4'hD, 32'h0, 32'h0, 1'b0);
        checkOutput("reset LO", busC, 32'd0);

        // Directed single-cycle corner values
        applyStimulus(4'h1, 32'h7FFFFFFF, 32'h1, 1'b0);
        checkOutput("add ovf busC", busC, 32'h80000000);
        checkOutput("add ovf OFsign", {31'd0, OFsign}, 32'd1);
        applyStimulus(4'h2, 32'd5, 32'd5, 1'b0);
        checkOutput("sub zero busC", busC, 32'd0);
        checkOutput("sub zero flag", {31'd0, zero}, 32'd1);
        applyStimulus(4'h5, 32'h80000000, 32'h1, 1'b0);
        checkOutput("slt neg", busC, 32'd1);
        applyStimulus(4'h6, 32'h1, 32'h23, 1'b0);
        checkOutput("sll mask", busC, 32'h8);
        applyStimulus(4'h7, 32'h0, 32'h1234, 1'b0);
        checkOutput("lui", busC, 32'h12340000);

        // Random single-cycle ops; start must have no sequential effect
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(1, 7));
            a = pickOperand();
            b = pickOperand();
            applyStimulus(op, a, b, 1'($urandom_range(0, 1)));
            refAlu(op, a, b, expRes, expOf);
            checkOutput($sformatf("rand op%0d busC", op), busC, expRes);
            checkOutput($sformatf("rand op%0d OFsign", op), {31'd0, OFsign}, {31'd0, expOf});
            checkOutput($sformatf("rand op%0d zero", op), {31'd0, zero}, {31'd0, expRes == 0});
            tick();
            checkOutput($sformatf("rand op%0d no busy", op), {31'd0, busy}, 32'd0);
        end

        // Directed multiply / divide
        runMulDiv(4'h8, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, "mult");
        runMulDiv(4'h9, 32'd3, 32'hFFFFFFFC, 32'h00000002, 32'hFFFFFFF4, "multu");
        runMulDiv(4'hA, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        runMulDiv(4'hB, 32'd7, 32'd2, 32'd1, 32'd3, "divu");
        runMulDiv(4'hA, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div min");
        runMulDiv(4'hB, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, "divu zero");

        // Random multiply / divide against the reference model
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(8, 11));
            a = pickOperand();
            b = pickOperand();
            refMulDiv(op, a, b, eh, el);
            runMulDiv(op, a, b, eh, el, $sformatf("rand md op%0h", op));
        end

        // Hazards: ignored relaunch and ignored mthi while busy, then a
        // stalled mflo that resolves in the done cycle.
        applyStimulus(4'h8, 32'h10000, 32'h10000, 1'b1);
        tick();
        cyc = 0;
        stallBad = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 2) applyStimulus(4'hA, 32'd7, 32'd2, 1'b1);
            else if (cyc == 3) applyStimulus(4'hE, 32'hAAAA5555, 32'h0, 1'b1);
            else if (cyc == 4) applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
            else if (cyc == 5) applyStimulus(4'hD, 32'h0, 32'h0, 1'b0);
            if (cyc >= 5 && stall !== 1'b1) stallBad++;
            tick();
        end
        checkOutput("hazard busy cycles", cyc, 32);
        checkOutput("hazard stall while busy", stallBad, 0);
        checkOutput("hazard done", {31'd0, done}, 32'd1);
        checkOutput("hazard stall released", {31'd0, stall}, 32'd0);
        checkOutput("hazard mflo", busC, 32'd0);
        applyStimulus(4'hC, 32'h0, 32'h0, 1'b0);
        checkOutput("hazard mfhi", busC, 32'd1);
        tick();
        checkOutput("hazard no relaunch", {31'd0, busy}, 32'd0);

        // Reset abort mid-divide
        applyStimulus(4'hA, 32'hFFFFFF9C, 32'd3, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
        cyc = 1;
        while (cyc < 10) begin
            cyc++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        applyStimulus(4'hC, 32'h0, 32'h0, 1'b0);
        checkOutput("abort HI", busC, 32'd0);
        applyStimulus(4'hD, 32'h0, 32'h0, 1'b0);
        checkOutput("abort LO", busC, 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) doneSeen++;
            tick();
        end
        checkOutput("abort no done later", doneSeen, 0);

        // Moves
        applyStimulus(4'hE, 32'hDEADBEEF, 32'h0, 1'b1);
        tick();
        applyStimulus(4'hF, 32'h1, 32'h0, 1'b1);
        tick();
        applyStimulus(4'hC, 32'h0, 32'h0, 1'b0);
        checkOutput("mthi", busC, 32'hDEADBEEF);
        applyStimulus(4'hD, 32'h0, 32'h0, 1'b0);
        checkOutput("mtlo", busC, 32'h1);

        // Back-to-back launch in the done cycle
        applyStimulus(4'h8, 32'd3, 32'd5, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        checkOutput("b2b first done", {31'd0, done}, 32'd1);
        applyStimulus(4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("b2b accepted", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        checkOutput("b2b busy cycles", cyc, 32);
        checkOutput("b2b second done", {31'd0, done}, 32'd1);
        applyStimulus(4'hC, 32'h0, 32'h0, 1'b0);
        checkOutput("b2b HI", busC, 32'hFFFFFFFE);
        applyStimulus(4'hD, 32'h0, 32'h0, 1'b0);
        checkOutput("b2b LO", busC, 32'h00000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation datapath ALU for the MIPS32 core.
- Keeps the single-cycle ops: nop, add, sub, and, or, slt, sll, lui.
- Adds iterative multiply/divide: signed and unsigned, one result bit per cycle, with HI/LO result registers and a start/busy/done handshake.
- Sits in EX; the control unit uses `stall` to freeze the pipeline while HI/LO are pending.

Parameters:
- WIDTH, 32, datapath width in bits; even, ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk      in   1        clock; all state updates on rising edge
- rst      in   1        synchronous, active-high reset
- busA     in   WIDTH    operand A (rs); dividend / multiplicand
- busB     in   WIDTH    operand B (rt); divisor / multiplier
- ALUOp    in   4        operation select
- start    in   1        instruction-valid qualifier for sequential ops (8–B, E, F)
- busC     out  WIDTH    combinational result
- zero     out  1        busC == 0
- OFsign   out  1        signed overflow of add/sub
- busy     out  1        mul/div iteration in progress
- done     out  1        one-cycle pulse: HI/LO just updated by mul/div
- stall    out  1        busy & (ALUOp ∈ {8,9,A,B,C,D,E,F})

Behaviour:
- Reset:
  - rst=1 at an edge clears HI, LO, iteration counter and internal shift registers; busy=0, done=0.
  - Reset mid-operation aborts the operation; HI/LO read 0.
- Op encoding:
  - 0 nop → busC = 0.
  - 1 add, 2 sub: WIDTH+1-bit sign-extended add/sub; busC = low WIDTH bits; OFsign = bit WIDTH XOR bit WIDTH-1. OFsign = 0 for all other ops.
  - 3 and, 4 or: bitwise.
  - 5 slt: busC = {0…, bit WIDTH of the (WIDTH+1)-bit signed A−B}; correct across overflow.
  - 6 sll: busC = busA << busB[SHW-1:0].
  - 7 lui: busC = busB << (WIDTH/2).
  - 8 mult, 9 multu, A div, B divu: busC = 0.
  - C mfhi → busC = HI; D mflo → busC = LO.
  - E mthi, F mtlo: busC = 0; on an edge with start=1 & busy=0, HI (resp. LO) ← busA.
- Launch: at an edge with start=1, busy=0 and ALUOp ∈ 8..B:
  - Operands and signedness are latched; busy=1 for exactly WIDTH cycles.
  - Operands are not sampled afterwards.
- Multiply:
  - Shift-add over operand magnitudes; signed product sign-corrected at the end.
  - {HI,LO} = full 2·WIDTH-bit product.
- Divide:
  - Restoring algorithm on magnitudes.
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend; still WIDTH cycles.
  - Signed MIN / −1: LO = MIN, HI = 0.
- Completion:
  - At the edge ending the WIDTH-th busy cycle, HI/LO are written.
  - In the following cycle busy=0 and done=1 (exactly one cycle).
  - The earliest new launch is in that same done cycle.
- Ignored inputs:
  - start while busy=1 is ignored (no relaunch, no mthi/mtlo write).
  - start with ALUOp ∈ 0..7, C, D has no sequential effect.
- Stall:
  - While busy, ops C/D/E/F and 8–B assert stall; busC still shows the stale HI/LO.
  - Control must hold the instruction until stall=0.
  - Ops 0–7 never stall.
- zero reflects busC for every op, including mfhi/mflo.

Test Plan:
- Reset, then single-cycle ops (WIDTH=32):
  - add 0x7FFFFFFF + 1 → busC 0x80000000, OFsign 1.
  - sub 5 − 5 → busC 0, zero 1.
  - slt 0x80000000 vs 1 → busC 1.
  - sll 1 by busB = 0x23 → busC 0x8.
  - lui 0x1234 → busC 0x12340000.
  - busy stays 0 throughout.
- mult 3 × 0xFFFFFFFC (−4):
  - busy high exactly 32 cycles, then done pulse.
  - mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFF4.
  - multu of the same operands → HI 0x00000002, LO 0xFFFFFFF4.
- div −7 / 2:
  - LO 0xFFFFFFFD, HI 0xFFFFFFFF.
  - divu 7 / 2 → LO 3, HI 1.
  - div 0x80000000 / 0xFFFFFFFF → LO 0x80000000, HI 0.
  - divu 9 / 0 → LO 0xFFFFFFFF, HI 9.
- Hazards during mult 0x10000 × 0x10000:
  - Second start with div mid-run → ignored.
  - mflo issued at busy cycle 5 → stall=1 until the done cycle, then busC = 0.
  - mfhi → 1.
- Reset abort:
  - Assert rst at busy cycle 10 of a div → next cycle busy 0, done 0, HI = LO = 0.
  - No done pulse afterwards.
- Moves and back-to-back launch:
  - mthi 0xDEADBEEF / mtlo 0x1 with start → mfhi/mflo return them.
  - Launch a new mult in the done cycle of the previous one → accepted, busy for a further 32 cycles.
